key_repeater: RTL and testbench



---
 rtl/key_repeater_if.sv | 15 +
 rtl/key_repeater.sv | 92 +++++++++
 tb/tb_key_repeater.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/key_repeater_if.sv
// Key repeater interface: bundles the debounced key level and the event outputs.
//   in            debounced key level (driven by the debouncer side)
//   pulse         one-cycle press / auto-repeat event
//   release_pulse one-cycle release event after an accepted press
//   held          high while an accepted press is in progress
// master: debouncer / front-panel side. slave: key_repeater.
interface key_repeater_if;
  logic in;
  logic pulse;
  logic release_pulse;
  logic held;

  modport master (output in, input pulse, input release_pulse, input held);
  modport slave  (input in, output pulse, output release_pulse, output held);
endinterface

// File: rtl/key_repeater.sv
// Key repeater: turns a debounced key level into single-cycle press/auto-repeat
// pulses, a one-cycle release event and a held level. All outputs are registered.
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous, active-high reset
//   key    key_repeater_if slave: in (key level), pulse, release_pulse, held
// After reset the block sits in a lockout state until the key is seen released,
// so a key held through reset produces no events.
module key_repeater #(
  parameter bit          ACTIVE_LOW    = 1'b0,
  parameter int unsigned DELAY_CYCLES  = 8,
  parameter int unsigned PERIOD_CYCLES = 4,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic         clk,
  input  logic         reset,
  key_repeater_if.slave key
);

  typedef enum logic [1:0] {StLockout, StIdle, StWait, StRepeat} state_e;

  localparam logic [CNT_WIDTH-1:0] DelayLast  = CNT_WIDTH'(DELAY_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] PeriodLast = CNT_WIDTH'(PERIOD_CYCLES - 1);

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 pulse_q;
  logic                 release_q;
  logic                 held_q;
  logic                 pressed;

  assign pressed = key.in ^ ACTIVE_LOW;

  assign key.pulse         = pulse_q;
  assign key.release_pulse = release_q;
  assign key.held          = held_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StLockout;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      release_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      // Events are single-cycle unless re-asserted below.
      pulse_q   <= 1'b0;
      release_q <= 1'b0;
      unique case (state_q)
        StLockout: begin
          if (!pressed) state_q <= StIdle;
        end
        StIdle: begin
          if (pressed) begin
            state_q <= StWait;
            cnt_q   <= '0;
            pulse_q <= 1'b1;
            held_q  <= 1'b1;
          end
        end
        StWait: begin
          if (!pressed) begin
            state_q   <= StIdle;
            release_q <= 1'b1;
            held_q    <= 1'b0;
          end else if (cnt_q == DelayLast) begin
            state_q <= StRepeat;
            cnt_q   <= '0;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRepeat: begin
          // Release wins over a coincident terminal count.
          if (!pressed) begin
            state_q   <= StIdle;
            release_q <= 1'b1;
            held_q    <= 1'b0;
          end else if (cnt_q == PeriodLast) begin
            cnt_q   <= '0;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StLockout;
      endcase
    end
  end

endmodule

// File: tb/tb_key_repeater.sv
// Testbench for key_repeater: two instances (active-high D=3/P=2 and
// active-low D=1/P=1) driven by directed scenarios then random stimulus,
// checked every cycle against a press-age reference model.
module tb_key_repeater;

  logic clk;
  logic reset;

  key_repeater_if if0 ();
  key_repeater_if if1 ();

  key_repeater #(
    .ACTIVE_LOW   (1'b0),
    .DELAY_CYCLES (3),
    .PERIOD_CYCLES(2),
    .CNT_WIDTH    (4)
  ) u_dut0 (
    .clk  (clk),
    .reset(reset),
    .key  (if0)
  );

  key_repeater #(
    .ACTIVE_LOW   (1'b1),
    .DELAY_CYCLES (1),
    .PERIOD_CYCLES(1),
    .CNT_WIDTH    (4)
  ) u_dut1 (
    .clk  (clk),
    .reset(reset),
    .key  (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int pulses0  = 0;
  int pulses1  = 0;

  // Reference model state, indexed by instance.
  int dly[2] = '{3, 1};
  int per[2] = '{2, 1};
  bit locked[2];
  bit active[2];
  int age[2];  // edges since the accepted press edge

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Outputs after an edge, as {pulse, release, held}.
  task automatic model_step(input int i, input bit rst, input bit pr, output logic [2:0] exp);
    bit p;
    bit r;
    bit h;
    p = 1'b0;
    r = 1'b0;
    h = 1'b0;
    if (rst) begin
      locked[i] = 1'b1;
      active[i] = 1'b0;
    end else if (locked[i]) begin
      if (!pr) locked[i] = 1'b0;
    end else if (!active[i]) begin
      if (pr) begin
        active[i] = 1'b1;
        age[i]    = 0;
        p = 1'b1;
        h = 1'b1;
      end
    end else if (!pr) begin
      active[i] = 1'b0;
      r = 1'b1;
    end else begin
      age[i]++;
      h = 1'b1;
      p = (age[i] == dly[i]) || (age[i] > dly[i] && ((age[i] - dly[i]) % per[i]) == 0);
    end
    exp = {p, r, h};
  endtask

  task automatic step(input bit rst, input bit a, input bit b);
    logic [2:0] e0;
    logic [2:0] e1;
    reset  = rst;
    if0.in = a;
    if1.in = b;
    @(posedge clk);
    model_step(0, rst, a, e0);
    model_step(1, rst, ~b, e1);
    #1;
    check("dut0 {pulse,release,held}", {29'd0, if0.pulse, if0.release_pulse, if0.held},
          {29'd0, e0});
    check("dut1 {pulse,release,held}", {29'd0, if1.pulse, if1.release_pulse, if1.held},
          {29'd0, e1});
    if (if0.pulse === 1'b1) pulses0++;
    if (if1.pulse === 1'b1) pulses1++;
  endtask

  initial begin
    bit a;
    bit b;
    // Reset with both keys pressed.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    // Held through reset: lockout, no events.
    pulses0 = 0;
    pulses1 = 0;
    repeat (10) step(1'b0, 1'b1, 1'b0);
    check("lockout pulses dut0", pulses0, 0);
    check("lockout pulses dut1", pulses1, 0);
    step(1'b0, 1'b0, 1'b1);  // release clears lockout
    // Press and hold 10 edges from e0.
    pulses0 = 0;
    pulses1 = 0;
    repeat (10) step(1'b0, 1'b1, 1'b0);
    check("hold pulses dut0", pulses0, 5);
    check("hold pulses dut1", pulses1, 10);
    step(1'b0, 1'b0, 1'b1);
    check("hold release dut0", {31'd0, if0.release_pulse}, 1);
    check("hold release dut1", {31'd0, if1.release_pulse}, 1);
    // Tap.
    pulses0 = 0;
    repeat (2) step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("tap pulses dut0", pulses0, 1);
    // Release on a repeat terminal-count edge (e0+5).
    repeat (5) step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("release vs repeat pulse", {31'd0, if0.pulse}, 0);
    step(1'b0, 1'b0, 1'b1);
    // Reset mid-REPEAT at e0+4, then key must be released and re-pressed.
    repeat (4) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    pulses0 = 0;
    repeat (3) step(1'b0, 1'b1, 1'b1);
    check("post-reset lockout dut0", pulses0, 0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("re-press pulse dut0", {31'd0, if0.pulse}, 1);
    // Release followed immediately by a re-press.
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 0, 1'b1);
    // Random phase: sticky key levels, occasional reset.
    a = 1'b0;
    b = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) a = ~a;
      if ($urandom_range(3) == 0) b = ~b;
      step($urandom_range(63) == 0, a, b);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
